// File: rtl/goofy_io_pkg.sv
// goofy_io_pkg: register offsets and STATUS/CTRL bit positions shared by the I/O responder.
package goofy_io_pkg;
   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_TXDATA = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;
   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_OVF   = 5;
   localparam int ST_BUS_ERR  = 6;
   localparam int CTRL_CLR    = 0;
   localparam int CTRL_FLUSH  = 1;
endpackage

// File: rtl/goofy_io_fifo.sv
// goofy_io_fifo: power-of-two circular FIFO; a push into a full FIFO succeeds only alongside a pop,
// and flush overrides any push/pop in the same cycle.
module goofy_io_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     res_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/goofy_io_resp.sv
// goofy_io_resp: 4-register I/O responder with TX/RX byte FIFOs and a one-cycle registered ack.
// GOOFY_IO_LOOPBACK_EN routes the TX FIFO head into the RX FIFO instead of the external ports.
module goofy_io_resp
   import goofy_io_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] ADDR_BASE = 8'h00
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_wdata,
   input  logic       io_wr,
   input  logic       io_rd,
   output logic [7:0] io_rdata,
   output logic       io_ack,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [7:0]    off, status, rdata_next, tx_head, rx_head, rx_din;
   logic [1:0]    reg_sel;
   logic          hit, rd, wr, tx_push, tx_pop, rx_push, rx_pop, flush, clr;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_ovf, rx_ovf, bus_err, tx_ovf_set, rx_ovf_set;
   logic [CW-1:0] tx_count, rx_count;
   // Unsigned modulo-256 offset keeps the decode correct even when the window wraps past 8'hFF.
   assign off     = io_addr - ADDR_BASE;
   assign reg_sel = off[1:0];
   assign hit     = off < 8'd4 && (io_rd || io_wr);
   assign rd      = hit && io_rd;
   assign wr      = hit && io_wr && !io_rd;
   assign tx_push = wr && reg_sel == REG_TXDATA;
   assign rx_pop  = rd && reg_sel == REG_RXDATA;
   assign flush   = wr && reg_sel == REG_CTRL && io_wdata[CTRL_FLUSH];
   assign clr     = wr && reg_sel == REG_CTRL && io_wdata[CTRL_CLR];
   assign tx_ovf_set = tx_push && tx_full && !tx_pop;
   assign tx_data = tx_empty ? 8'h00 : tx_head;
`ifdef GOOFY_IO_LOOPBACK_EN
   assign tx_pop     = !tx_empty && !rx_full;
   assign rx_push    = tx_pop;
   assign rx_din     = tx_head;
   assign tx_valid   = 1'b0;
   assign rx_ovf_set = 1'b0;
`else
   assign tx_valid   = !tx_empty;
   assign tx_pop     = tx_valid && tx_ready;
   assign rx_push    = rx_valid;
   assign rx_din     = rx_data;
   assign rx_ovf_set = rx_valid && rx_full && !rx_pop;
`endif
   goofy_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx (
      .clk(clk), .res_n(res_n), .push(tx_push), .pop(tx_pop), .flush(flush), .din(io_wdata),
      .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );
   goofy_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx (
      .clk(clk), .res_n(res_n), .push(rx_push), .pop(rx_pop), .flush(flush), .din(rx_din),
      .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );
   always_comb begin
      status = 8'h00;
      status[ST_TX_FULL]  = tx_count == CW'(DEPTH);
      status[ST_TX_EMPTY] = tx_count == '0;
      status[ST_RX_EMPTY] = rx_count == '0;
      status[ST_RX_FULL]  = rx_count == CW'(DEPTH);
      status[ST_TX_OVF]   = tx_ovf;
      status[ST_RX_OVF]   = rx_ovf;
      status[ST_BUS_ERR]  = bus_err;
      rdata_next = reg_sel == REG_STATUS ? status :
                   reg_sel == REG_RXDATA ? (rx_empty ? 8'h00 : rx_head) : 8'h00;
   end
   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         io_ack   <= 1'b0;
         io_rdata <= 8'h00;
         tx_ovf   <= 1'b0;
         rx_ovf   <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         io_ack   <= hit;
         io_rdata <= rd ? rdata_next : 8'h00;
         tx_ovf   <= tx_ovf_set || (tx_ovf && !clr);
         rx_ovf   <= rx_ovf_set || (rx_ovf && !clr);
         bus_err  <= (hit && io_rd && io_wr) || (bus_err && !clr);
      end
endmodule

// File: tb/tb_goofy_io_resp.sv
// tb_goofy_io_resp: directed self-checking bench for goofy_io_resp (DEPTH=4, ADDR_BASE=0).
module tb_goofy_io_resp;
   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic [7:0] io_addr = 8'h00, io_wdata = 8'h00, rx_data = 8'h00;
   logic       io_wr = 1'b0, io_rd = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0] io_rdata, tx_data;
   logic       io_ack, tx_valid;
   int         checks = 0, errors = 0;

   goofy_io_resp #(.DEPTH(4), .ADDR_BASE(8'h00)) dut (
      .clk(clk), .res_n(res_n), .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr),
      .io_rd(io_rd), .io_rdata(io_rdata), .io_ack(io_ack), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
   );

   always #5 clk = ~clk;

   task automatic bus(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic ack, output logic [7:0] q);
      @(negedge clk);
      io_rd = r; io_wr = w; io_addr = a; io_wdata = d;
      @(negedge clk);
      ack = io_ack; q = io_rdata;
      io_rd = 1'b0; io_wr = 1'b0;
   endtask

   task automatic test_reset;
      logic ack; logic [7:0] q;
      res_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", io_ack); end
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", io_rdata); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      res_n = 1'b1;
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h06) begin errors++; $display("FAIL reset_status got ack=%b %h want ack=1 06", ack, q); end
   endtask

   task automatic test_tx;
      logic ack; logic [7:0] q;
      bus(0, 1, 8'h01, 8'hA5, ack, q);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL tx_wr_ack got %b want 1", ack); end
      bus(0, 1, 8'h01, 8'h3C, ack, q);
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h04) begin errors++; $display("FAIL tx_status got %h want 04", q); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL tx_head0 got v=%b %h want v=1 a5", tx_valid, tx_data); end
      tx_ready = 1'b1;
      @(negedge clk);
      checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL tx_head1 got %h want 3c", tx_data); end
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got %b want 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_tx_overflow;
      logic ack; logic [7:0] q;
      for (int i = 1; i <= 5; i++) bus(0, 1, 8'h01, 8'(i), ack, q);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovf_5th_ack got %b want 1", ack); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h15) begin errors++; $display("FAIL ovf_status got %h want 15", q); end
      bus(0, 1, 8'h03, 8'h01, ack, q);
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h05) begin errors++; $display("FAIL ovf_cleared got %h want 05", q); end
      checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL ovf_head got %h want 01", tx_data); end
      tx_ready = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, tx_data, 8'(i)); end
      end
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got valid=%b want 0", tx_valid); end
      tx_ready = 1'b0;
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL ovf_final_status got %h want 06", q); end
   endtask

   task automatic test_rx;
      logic ack; logic [7:0] q;
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h11;
      @(negedge clk); rx_valid = 1'b0;
      bus(1, 0, 8'h02, 8'h00, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h11) begin errors++; $display("FAIL rx_read1 got ack=%b %h want ack=1 11", ack, q); end
      bus(1, 0, 8'h02, 8'h00, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h00) begin errors++; $display("FAIL rx_read_empty got ack=%b %h want ack=1 00", ack, q); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL rx_status got %h want 06", q); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); rx_valid = 1'b1; rx_data = 8'h31 + 8'(i);
      end
      @(negedge clk); rx_valid = 1'b0;
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h2A) begin errors++; $display("FAIL rx_ovf_status got %h want 2a", q); end
      bus(1, 0, 8'h02, 8'h00, ack, q);
      checks++; if (q !== 8'h31) begin errors++; $display("FAIL rx_ovf_head got %h want 31", q); end
      bus(0, 1, 8'h03, 8'h03, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h00) begin errors++; $display("FAIL ctrl_wr got ack=%b %h want ack=1 00", ack, q); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL rx_flush_status got %h want 06", q); end
   endtask

   task automatic test_bus_err;
      logic ack; logic [7:0] q;
      bus(1, 1, 8'h01, 8'h77, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h00) begin errors++; $display("FAIL both_ack got ack=%b %h want ack=1 00", ack, q); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL both_no_push got %b want 0", tx_valid); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h46) begin errors++; $display("FAIL both_status got %h want 46", q); end
      bus(0, 1, 8'h03, 8'h01, ack, q);
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL both_cleared got %h want 06", q); end
   endtask

   task automatic test_out_of_range;
      logic ack; logic [7:0] q;
      bus(0, 1, 8'h04, 8'h55, ack, q);
      checks++; if (ack !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL oor_wr got ack=%b v=%b want 0 0", ack, tx_valid); end
      bus(1, 0, 8'hFF, 8'h00, ack, q);
      checks++; if (ack !== 1'b0 || q !== 8'h00) begin errors++; $display("FAIL oor_rd got ack=%b %h want ack=0 00", ack, q); end
   endtask

   task automatic test_back_to_back;
      logic a1, a2;
      @(negedge clk); io_wr = 1'b1; io_addr = 8'h01; io_wdata = 8'h21;
      @(negedge clk); a1 = io_ack; io_wdata = 8'h22;
      @(negedge clk); a2 = io_ack; io_wr = 1'b0;
      checks++; if (a1 !== 1'b1 || a2 !== 1'b1) begin errors++; $display("FAIL b2b_acks got %b%b want 11", a1, a2); end
      checks++; if (tx_data !== 8'h21) begin errors++; $display("FAIL b2b_head0 got %h want 21", tx_data); end
      tx_ready = 1'b1;
      @(negedge clk);
      checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL b2b_head1 got %h want 22", tx_data); end
      @(negedge clk);
      tx_ready = 1'b0;
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_single got %b want 0", io_ack); end
   endtask

   task automatic test_reset_mid_request;
      logic ack; logic [7:0] q;
      bus(0, 1, 8'h01, 8'h99, ack, q);
      @(negedge clk); io_rd = 1'b1; io_addr = 8'h00;
      @(posedge clk); #2; res_n = 1'b0; io_rd = 1'b0;
      @(negedge clk);
      checks++; if (io_ack !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got ack=%b v=%b want 0 0", io_ack, tx_valid); end
      res_n = 1'b1;
      @(negedge clk);
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_after got ack=%b want 0", io_ack); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL rst_mid_status got %h want 06", q); end
   endtask

   task automatic test_loopback;
      logic ack; logic [7:0] q;
      bus(0, 1, 8'h01, 8'h42, ack, q);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL lb_tx_valid got %b want 0", tx_valid); end
      bus(1, 0, 8'h02, 8'h00, ack, q);
      checks++; if (ack !== 1'b1 || q !== 8'h42) begin errors++; $display("FAIL lb_rx got ack=%b %h want ack=1 42", ack, q); end
      bus(1, 0, 8'h00, 8'h00, ack, q);
      checks++; if (q !== 8'h06) begin errors++; $display("FAIL lb_status got %h want 06", q); end
   endtask

   initial begin
      test_reset;
`ifdef GOOFY_IO_LOOPBACK_EN
      test_loopback;
`else
      test_tx;
      test_tx_overflow;
      test_rx;
      test_bus_err;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid_request;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/goofy_io_resp.md
# goofy_io_resp

Memory-mapped I/O responder sitting on the core's I/O bus: the target of the microcode I/O read/write strobes. Decodes a 4-register map and buffers bytes in a TX FIFO toward an external console sink and an RX FIFO from an external source. Every request gets a one-cycle-latency acknowledge with registered read data. It is the responder end of the I/O protocol the core initiates.

## Interface
- DEPTH, 4: entries per FIFO; power of two, 2..16.
- ADDR_BASE, 8'h00: base I/O address; the block decodes ADDR_BASE..ADDR_BASE+3.
- clk  in  1  system clock; all logic on posedge.
- res_n  in  1  reset, asynchronous, active-low.
- io_addr  in  8  request address.
- io_wdata  in  8  write data.
- io_wr  in  1  write strobe; 1-cycle request.
- io_rd  in  1  read strobe; 1-cycle request.
- io_rdata  out  8  read data, valid while io_ack=1.
- io_ack  out  1  1-cycle acknowledge for an in-range request.
- tx_data  out  8  head of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  sink accepts; pop when tx_valid&&tx_ready.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  push strobe; no backpressure.

## Operation
- Register map, offsets from ADDR_BASE:
  - 0 STATUS (RO): bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 tx_ovf, bit5 rx_ovf, bit6 bus_err; bit7 = 0.
  - 1 TXDATA (WO): push io_wdata. Reads return 0.
  - 2 RXDATA (RO): return the head entry and pop it. If empty, return 8'h00 with no pop.
  - 3 CTRL (W): bit0 clears tx_ovf/rx_ovf/bus_err; bit1 flushes both FIFOs. Reads return 0.
- Out-of-range address: ignored, no io_ack, no state change.
- io_rd and io_wr both high, in range: the read executes, the write is dropped, bus_err is set, and io_ack is asserted.
- Write to TXDATA while full: byte dropped, tx_ovf set (sticky).
- rx_valid while RX full: byte dropped, rx_ovf set (sticky). When RX is full, a pop and a push in the same cycle are both performed and no overflow occurs.
- TX pop (tx_ready) and bus push in the same cycle: both performed. Full/empty flags reflect the resulting count.
- Sticky flags are cleared only by CTRL bit0 or reset. If a set event and a clear occur in the same cycle, set wins.
- CTRL flush in the same cycle as a push or pop: flush wins and both counts become 0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Requests are sampled at posedge N. io_ack and io_rdata are registered and valid in cycle N+1 for exactly one cycle.
- Back-to-back requests are legal, one per cycle, each acked in the following cycle.
- STATUS read at N reflects state before any push/pop at edge N.
- A push at edge N makes tx_valid high from N+1. tx_data is the head combinationally from FIFO storage.
- Reset (res_n low, any time including mid-request): io_ack=0, io_rdata=0, tx_valid=0, tx_data=0, both FIFOs empty, all sticky flags 0. A pending ack is discarded.
- First request is accepted at the first posedge after res_n deasserts.

## Configuration
- GOOFY_IO_LOOPBACK_EN defined: the TX FIFO output is routed into the RX FIFO push internally. rx_valid/rx_data are ignored and tx_valid is held 0.
  - Transfer occurs when TX is non-empty and RX is not full.
  - One byte per cycle.
  - Loopback never sets rx_ovf.
- GOOFY_IO_LOOPBACK_EN undefined: external ports are used as described above.

## Structure
- Package goofy_io_pkg:
  - Register offsets REG_STATUS=0, REG_TXDATA=1, REG_RXDATA=2, REG_CTRL=3.
  - STATUS bit positions.
  - CTRL bit positions.
- Sub-module goofy_io_fifo (parameter DEPTH, WIDTH=8):
  - Inputs: push, pop, flush.
  - Outputs: head, full, empty, count.
  - Handles simultaneous push+pop.
  - Instantiated twice (TX, RX).

## Test plan
- Write 8'hA5 then 8'h3C to TXDATA with tx_ready=0 → STATUS reads 8'h04 (RX empty, TX partially filled). Raise tx_ready → tx_data is A5 then 3C, then tx_valid=0.
- Write 5 bytes to TXDATA with DEPTH=4 and tx_ready=0 → the 5th write is acked and dropped. STATUS bit4=1 and bit0=1. Writing CTRL=8'h01 clears bit4.
- Push 8'h11 via rx_valid, then read RXDATA twice → ack with 8'h11, then ack with 8'h00. STATUS bit2=1 afterwards.
- Assert io_rd and io_wr together to TXDATA → io_ack=1, no push, STATUS bit6=1.
- Pull res_n low the cycle after a read request → io_ack stays 0, STATUS reads 8'h06 after release.
- With GOOFY_IO_LOOPBACK_EN: write 8'h42 to TXDATA → RXDATA read returns 8'h42 within 3 cycles, and tx_valid stays 0.
